// File: rtl/sw_debounce_ctrl_pkg.sv
// Shared definitions for the switch I/O subsystem: the Avalon register map,
// CTRL bit layout and its reset value, and a small write-strobe helper.
package sw_debounce_ctrl_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_BOTH_BIT = 1;

  // CTRL layout: packed so that en lands on bit 0 and both_edges on bit 1
  typedef struct packed {
    logic both_edges;
    logic en;
  } ctrl_t;

  // Out of reset: enabled, rising edges only
  localparam ctrl_t CTRL_RST = '{both_edges: 1'b0, en: 1'b1};

  // Avalon write qualifier: write_n is active low
  function automatic logic avl_wr(input logic cs, input logic wn);
    return cs & ~wn;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch lane: 2-flop synchronizer, 3-deep tick-sampled history and the
// stable-compare that updates the debounced level the cycle after a tick.
//   clk, reset_n : clock, async active-low reset
//   din          : raw asynchronous switch level
//   tick         : 1-cycle sample strobe from the shared prescaler
//   level        : debounced level
//   rise / fall  : 1-cycle pulses, high in the cycle before level changes,
//                  so edge capture lands on the same edge as the level update
module sw_debounce_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic [2:0] hist;
  logic       tick_d;
  logic       stable;
  logic       upd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      hist   <= '0;
      tick_d <= 1'b0;
      level  <= 1'b0;
    end else begin
      sync   <= {sync[0], din};
      tick_d <= tick;
      if (tick) hist  <= {hist[1:0], sync[1]};
      if (upd)  level <= hist[0];
    end
  end

  // Only evaluated right after a shift, so a frozen prescaler freezes level.
  assign stable = (hist == 3'b000) || (hist == 3'b111);
  assign upd    = tick_d && stable && (hist[0] != level);
  assign rise   = upd &  hist[0];
  assign fall   = upd & ~hist[0];

endmodule

// File: rtl/sw_debounce_ctrl.sv
// Debounced switch input port with Avalon-MM slave, edge capture and
// level interrupt.
//   clk, reset_n         : clock, async active-low reset
//   address, chipselect,
//   write_n, writedata   : Avalon-MM slave write side
//   readdata             : registered read data, 1-cycle latency always
//   in_port              : raw asynchronous switch levels
//   irq                  : OR of (EDGECAP & IRQMASK), from registers only
module sw_debounce_ctrl
  import sw_debounce_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0]      cnt;
  logic             tick;
  ctrl_t            ctrl;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr;

  assign wr = avl_wr(chipselect, write_n);

  // Prescaler: parked at 0 while disabled so re-enable starts a full period.
  assign tick = ctrl.en && (cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     cnt <= '0;
    else if (!ctrl.en) cnt <= '0;
    else if (tick)     cnt <= '0;
    else               cnt <= cnt + 16'd1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .tick    (tick),
      .level   (data[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  assign cap_set = rise | (fall & {WIDTH{ctrl.both_edges}});
  assign cap_clr = (wr && address == ADDR_EDGECAP) ? writedata : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = data;
      ADDR_IRQMASK: rd_mux = irqmask;
      ADDR_EDGECAP: rd_mux = edgecap;
      ADDR_CTRL:    rd_mux[1:0] = ctrl;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask  <= '0;
      edgecap  <= '0;
      ctrl     <= CTRL_RST;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      // Set applied after clear so a coinciding edge is never lost.
      edgecap  <= (edgecap & ~cap_clr) | cap_set;
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata;
      if (wr && address == ADDR_CTRL)    ctrl    <= ctrl_t'(writedata[1:0]);
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
module tb_sw_debounce_ctrl;

  localparam int W  = 8;
  localparam int TD = 4;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_CAP  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [W-1:0] writedata = '0;
  logic [W-1:0] readdata;
  logic [W-1:0] in_port = '0;
  logic         irq;

  always #5 clk = ~clk;

  sw_debounce_ctrl #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  typedef struct {
    string        name;
    logic [W-1:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_seen = 1'b0;
  logic irq_seen = 1'b0;
  logic irq_probe = 1'b0;

  // A read sampled at a rising edge is visible on readdata after that edge.
  always @(posedge clk) begin
    rd_seen  <= chipselect && write_n;
    irq_seen <= irq_probe;
  end

  // Monitor: pops expected values whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rd_seen) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %02h with no expectation", readdata);
      end else begin
        e = rd_q.pop_front();
        if (readdata !== e.val) begin
          errors++;
          $display("FAIL %s got %02h expected %02h", e.name, readdata, e.val);
        end
      end
    end
    if (irq_seen) begin
      checks++;
      if (irq_q.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected got %0b with no expectation", irq);
      end else begin
        e = irq_q.pop_front();
        if (irq !== e.val[0]) begin
          errors++;
          $display("FAIL %s got irq=%0b expected irq=%0b", e.name, irq, e.val[0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [W-1:0] v, input string nm);
    exp_t e;
    e.name = nm; e.val = v;
    rd_q.push_back(e);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic chk_irq(input logic v, input string nm);
    exp_t e;
    e.name = nm; e.val = {{(W-1){1'b0}}, v};
    irq_q.push_back(e);
    irq_probe = 1'b1;
    @(negedge clk);
    irq_probe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc(3);
    reset_n = 1'b1;
    cyc(1);

    // Reset state
    rd(A_DATA, 8'h00, "rst_data");
    rd(A_MASK, 8'h00, "rst_irqmask");
    rd(A_CAP,  8'h00, "rst_edgecap");
    rd(A_CTRL, 8'h01, "rst_ctrl");
    chk_irq(1'b0, "rst_irq");

    // Glitch of 5 cycles never fills the history
    in_port = 8'h01; cyc(5);
    in_port = 8'h00; cyc(20);
    rd(A_DATA, 8'h00, "glitch_data");
    rd(A_CAP,  8'h00, "glitch_edgecap");

    // Clean step, worst-case latency 3*TD+3 = 15 cycles
    in_port = 8'h05; cyc(15);
    rd(A_DATA, 8'h05, "step_data");
    rd(A_CAP,  8'h05, "step_edgecap");
    chk_irq(1'b0, "step_irq_masked");

    // Masked interrupt and write-1-to-clear
    in_port = 8'h04; cyc(20);
    wr(A_CAP, 8'hFF);
    wr(A_MASK, 8'h01);
    rd(A_MASK, 8'h01, "irqmask_rw");
    chk_irq(1'b0, "irq_before_rise");
    in_port = 8'h05; cyc(15);
    chk_irq(1'b1, "irq_on_rise");
    wr(A_CAP, 8'h01);
    chk_irq(1'b0, "irq_after_clear");
    rd(A_CAP, 8'h00, "edgecap_cleared");
    wr(A_MASK, 8'h00);

    // Falling edge captured only with BOTH_EDGES
    wr(A_CTRL, 8'h03);
    rd(A_CTRL, 8'h03, "ctrl_rw");
    in_port = 8'h0D; cyc(20);
    wr(A_CAP, 8'hFF);
    in_port = 8'h05; cyc(20);
    rd(A_CAP, 8'h08, "both_edges_fall");
    wr(A_CTRL, 8'h01);
    in_port = 8'h0D; cyc(20);
    wr(A_CAP, 8'hFF);
    in_port = 8'h05; cyc(20);
    rd(A_CAP, 8'h00, "rise_only_fall");

    // EN=0 freezes DATA; re-enable resumes within 15 cycles
    in_port = 8'h00; cyc(20);
    wr(A_CAP, 8'hFF);
    wr(A_CTRL, 8'h00);
    in_port = 8'hFF; cyc(40);
    rd(A_DATA, 8'h00, "frozen_data");
    rd(A_CAP,  8'h00, "frozen_edgecap");
    wr(A_CTRL, 8'h01);
    cyc(14);
    rd(A_DATA, 8'hFF, "resume_data");
    rd(A_CAP,  8'hFF, "resume_edgecap");
    wr(A_DATA, 8'h00);
    rd(A_DATA, 8'hFF, "data_write_ignored");

    // Clear coinciding with capture: prescaler phase pinned by EN toggle,
    // third tick at B+12, DATA/EDGECAP update at B+13.
    in_port = 8'h00; cyc(20);
    wr(A_CAP, 8'hFF);
    rd(A_DATA, 8'h00, "pre_collide_data");
    wr(A_CTRL, 8'h00);
    in_port = 8'h02; cyc(5);
    wr(A_CTRL, 8'h01);
    cyc(12);
    wr(A_CAP, 8'h02);
    rd(A_CAP, 8'h02, "set_wins_over_clear");
    wr(A_CAP, 8'h02);
    rd(A_CAP, 8'h00, "clear_after_collide");

    // Reset mid-debounce discards partial history
    in_port = 8'h10; cyc(6);
    reset_n = 1'b0; cyc(2);
    reset_n = 1'b1; cyc(15);
    rd(A_DATA, 8'h10, "post_reset_data");
    rd(A_CAP,  8'h10, "post_reset_edgecap");
    rd(A_CTRL, 8'h01, "post_reset_ctrl");
    chk_irq(1'b0, "post_reset_irq");

    cyc(3);
    checks++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending expected 0/0", rd_q.size(), irq_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce_ctrl.md
SW_DEBOUNCE_CTRL -- requirements
Module: sw_debounce_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, number of switch inputs.
REQ-002 Parameter TICK_DIV, default 50000, clk cycles per sample tick (1 ms at 50 MHz); legal range 2..65535.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active low; a write occurs only when chipselect=1 and write_n=0.
REQ-008 writedata  input  WIDTH  Avalon-MM write data.
REQ-009 readdata  output  WIDTH  registered read data.
REQ-010 in_port  input  WIDTH  raw, asynchronous switch levels.
REQ-011 irq  output  1  level interrupt request, active high.

Function
REQ-012 Register map: 0 = DATA (debounced levels, RO); 1 = IRQMASK (RW); 2 = EDGECAP (R; write-1-to-clear); 3 = CTRL (RW; bit0 EN, bit1 BOTH_EDGES; other bits read 0).
REQ-013 readdata SHALL register the addressed value every cycle regardless of chipselect (fixed 1-cycle read latency, zero wait states).
REQ-014 in_port SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-015 Prescaler: counts 0..TICK_DIV-1 while EN=1 and asserts a 1-cycle tick when it wraps from TICK_DIV-1 to 0; while EN=0 it SHALL hold at 0 with no ticks.
REQ-016 On each tick, each bit SHALL shift its synchronized level into a 3-deep history.
REQ-017 A DATA bit SHALL update on the cycle after a tick only if all 3 history entries are equal and differ from the current DATA bit; otherwise DATA holds.
REQ-018 Input-to-DATA latency for a clean step: 2 sync cycles + 3 ticks + 1 cycle, at most 3*TICK_DIV+3 cycles.
REQ-019 EDGECAP bit n SHALL set when DATA bit n rises (BOTH_EDGES=0) or on any DATA bit n change (BOTH_EDGES=1).
REQ-020 EDGECAP bits SHALL be sticky until cleared by writing 1 to that bit at address 2; if a set and a clear coincide in the same cycle, set wins.
REQ-021 irq SHALL equal OR-reduce(EDGECAP & IRQMASK), driven from registers (no combinational path from Avalon inputs).
REQ-022 Clearing EN SHALL freeze DATA and history; re-setting EN SHALL resume from the frozen state without spurious edges.
REQ-023 Writes to address 0 SHALL be ignored; writes to CTRL take effect on the next cycle.

Reset
REQ-024 Reset SHALL clear the synchronizer, history, prescaler, DATA, EDGECAP, IRQMASK, and readdata to 0, set CTRL to 0x01 (EN=1, rising edges only), and drive irq=0.
REQ-025 Reset asserted mid-debounce SHALL discard partial history; after release, DATA starts from 0 and a switch held high produces one EDGECAP rising event.

Structure
REQ-026 Register address constants (DATA, IRQMASK, EDGECAP, CTRL) and CTRL bit positions SHALL live in the shared package for the switch I/O subsystem.
REQ-027 The per-bit synchronizer plus 3-deep history plus stable compare SHALL be one sub-module, sw_debounce_bit, instantiated WIDTH times; prescaler and register file stay in the top.

Verification (bench uses TICK_DIV=4)
REQ-028 Reset release with in_port=0x00, then in_port=0x05 held -> DATA reads 0x05 within 15 cycles; EDGECAP=0x05; irq=0 (mask 0).
REQ-029 Glitch: in_port bit0 high for 5 cycles then low -> DATA bit0 stays 0 and EDGECAP stays 0x00.
REQ-030 IRQMASK=0x01, bit0 rises -> irq=1; write 0x01 to address 2 -> irq=0 on the following cycle and EDGECAP reads 0x00.
REQ-031 CTRL=0x03, bit3 toggles 1->0 after settling -> EDGECAP bit3 set; with CTRL=0x01 the same fall leaves EDGECAP bit3 clear.
REQ-032 CTRL=0x00, in_port changes 0x00->0xFF -> DATA remains 0x00 for 40 cycles; CTRL=0x01 -> DATA=0xFF within 15 cycles.
REQ-033 Clear write to EDGECAP bit1 issued on the same cycle bit1's rising edge is captured -> EDGECAP bit1 reads 1.
